// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core. One plaintext block is accepted per
// valid/ready handshake. The core then runs one full AES round per clock and
// holds the ciphertext on a valid/ready output until it is consumed.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  plaintext handshake (in_ready high only in idle)
//   plaintext[127:0]     FIPS-197 byte 0 at [127:120], column-major state
//   round_keys[0:10]     expanded keys, same byte order; [0] is the cipher key
//   out_valid/out_ready  ciphertext handshake
//   ciphertext[127:0]    result block, held stable while out_valid is high
//   busy                 high while a block is in flight or awaiting drain
//
// Build option:
//   AES_KEY_LATCH_EN     when defined, all 11 round keys are captured on the
//                        accept edge, so round_keys may change afterwards.
//                        When undefined, round_keys must stay stable from the
//                        accept edge until out_valid rises.
module aes128_encrypt_core #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_keys [0:10],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  localparam logic [3:0] LastRnd = 4'(NR);

  // Byte 0 of the table sits in the most significant byte of the constant.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes fused with ShiftRows: row r of column c comes from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] rk, sr_out, mc_out;

`ifdef AES_KEY_LATCH_EN
  logic [127:0] key_q [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) key_q[i] <= '0;
    end else if (state_q == StIdle && in_valid) begin
      for (int i = 0; i <= 10; i++) key_q[i] <= round_keys[i];
    end
  end

  assign rk = key_q[rnd_q];
`else
  assign rk = round_keys[rnd_q];
`endif

  assign sr_out = sub_shift(st_q);
  assign mc_out = mix_columns(sr_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      st_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    ct_d    = ct_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          st_d    = plaintext ^ round_keys[0];
          rnd_d   = 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        if (rnd_q == LastRnd) begin
          // Final round omits MixColumns; counter parks at 0 rather than wrapping.
          ct_d    = sr_out ^ rk;
          rnd_d   = '0;
          state_d = StDone;
        end else begin
          st_d  = mc_out ^ rk;
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    ciphertext = ct_q;
  end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core. Expected values come from a
// byte-level AES model whose S-box is derived from GF(2^8) inversion plus the
// affine map, with its own key expansion.
module tb_aes128_encrypt_core;

  typedef logic [0:10][127:0] keys_t;

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, ciphertext;
  logic [127:0] round_keys [0:10];

  int num_checks = 0;
  int num_fail   = 0;

  logic [7:0] sbox_tbl [256];

  aes128_encrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic keys_t key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    keys_t       ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input keys_t rk);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tbl[blk[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w + 4*c] = s[w + 4*((c + w) % 4)];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          if (r == 10) s[w + 4*c] = t[w + 4*c];
          else s[w + 4*c] = gmul(8'h02, t[w + 4*c]) ^ gmul(8'h03, t[(w + 1) % 4 + 4*c])
                            ^ t[(w + 2) % 4 + 4*c] ^ t[(w + 3) % 4 + 4*c];
      for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
      blk = blk ^ rk[r];
    end
    return blk;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input keys_t k);
    for (int i = 0; i <= 10; i++) round_keys[i] = k[i];
  endtask

  // Waits (bounded) for in_ready, then presents one block for a single edge.
  task automatic accept(input logic [127:0] pt);
    int n;
    n = 0;
    plaintext = pt;
    in_valid  = 1'b1;
    while (!in_ready && n < 20) begin step(); n++; end
    check("accept_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin step(); lat++; end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    keys_t        kb, kc, kr, used;
    logic [127:0] pt, key;
    int           lat;

    build_sbox();
    kb = key_expand(KeyB);
    kc = key_expand(KeyC);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0;
    load_keys(kb);
    step(); step();
    check("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    check("reset_ct", ciphertext, '0);
    rst = 1'b0;

    // FIPS-197 Appendix B
    accept(PtB);
    wait_out(lat);
    check("b_latency", 128'(lat), 128'(10));
    check("b_ct", ciphertext, CtB);
    drain();

    // Appendix C.1 with 20 cycles of backpressure
    load_keys(kc);
    accept(PtC);
    wait_out(lat);
    check("c_latency", 128'(lat), 128'(10));
    for (int i = 0; i < 20; i++) begin
      check("bp_ct", ciphertext, CtC);
      check("bp_flags", 128'({in_ready, out_valid, busy}), 128'(3'b011));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_on_drain", 128'(in_ready), 128'(0));
    step();
    out_ready = 1'b0;
    check("bp_idle_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // in_valid/plaintext churn while busy must not disturb the block
    load_keys(kb);
    accept(PtB);
    in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 30) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      step();
      lat++;
    end
    check("ign_latency", 128'(lat), 128'(10));
    check("ign_ct", ciphertext, CtB);
    pt = {$urandom, $urandom, $urandom, $urandom};
    plaintext = pt;
    step();
    check("ign_done_flags", 128'({in_ready, out_valid, busy}), 128'(3'b011));
    check("ign_done_ct", ciphertext, CtB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ign_back_idle", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check("ign_second_latency", 128'(lat), 128'(10));
    check("ign_second_ct", ciphertext, aes_ref(pt, kb));
    drain();

    // Reset while round 5 is pending
    accept(PtB);
    step(); step(); step(); step();
    check("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    step();
    check("mid_reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    check("mid_reset_ct", ciphertext, '0);
    rst = 1'b0;
    load_keys(kc);
    accept(PtC);
    wait_out(lat);
    check("mid_c_latency", 128'(lat), 128'(10));
    check("mid_c_ct", ciphertext, CtC);
    drain();

    // Round keys randomised every cycle after acceptance
    load_keys(kb);
    accept(PtB);
    used = kb;
    lat = 0;
    while (!out_valid && lat < 30) begin
      for (int i = 0; i <= 10; i++) round_keys[i] = {$urandom, $urandom, $urandom, $urandom};
      if (lat < 10) used[lat + 1] = round_keys[lat + 1];
      step();
      lat++;
    end
    check("key_latency", 128'(lat), 128'(10));
`ifdef AES_KEY_LATCH_EN
    check("key_latch_ct", ciphertext, CtB);
`else
    // Without the latch each round sees whatever key was on the bus at its edge.
    check("key_nolatch_ct", ciphertext, aes_ref(PtB, used));
    check("key_nolatch_differs", 128'(ciphertext != CtB), 128'(1));
`endif
    drain();

    // Random keys and plaintexts
    for (int b = 0; b < 6; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      kr  = key_expand(key);
      load_keys(kr);
      accept(pt);
      wait_out(lat);
      check("rand_latency", 128'(lat), 128'(10));
      check("rand_ct", ciphertext, aes_ref(pt, kr));
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
